// File: rtl/load_store_unit_if.sv
// Request/response handshake and BRAM port bundle between the control unit,
// the load/store unit and the data memory.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int BUS_WIDTH  = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [BUS_WIDTH-1:0]  req_wdata;
  logic                  rsp_valid;
  logic [BUS_WIDTH-1:0]  rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_we;
  logic [BUS_WIDTH-1:0]  mem_wdata;
  logic [BUS_WIDTH-1:0]  mem_rdata;

  // Control unit and memory side.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_wdata
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// OTTER data-memory initiator: byte-lane stores, extended loads, and splitting of
// word-crossing misaligned accesses into two BRAM accesses.
module load_store_unit #(
  parameter int ADDR_WIDTH = 13,
  parameter int BUS_WIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LD_A, LD_B, LD_W, ST_A, ST_B} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [3:0]            r_mem_we;
  logic [BUS_WIDTH-1:0]  r_mem_wdata;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [BUS_WIDTH-1:0]  r_rsp_rdata;
  logic [1:0]            r_off;
  logic [2:0]            r_funct3;
  logic                  r_split;
  logic [3:0]            r_hi_we;
  logic [BUS_WIDTH-1:0]  r_hi_wdata;
  logic [BUS_WIDTH-1:0]  r_lo_word;

  logic                  w_ready;
  logic                  w_accept;
  logic [1:0]            w_off;
  logic [2:0]            w_size;
  logic [3:0]            w_size_mask;
  logic [31:0]           w_byte_mask;
  logic                  w_split;
  logic                  w_illegal;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [7:0]            w_lane_mask;
  logic [63:0]           w_lane_data;
  logic [31:0]           w_lo_word;
  logic [31:0]           w_hi_word;
  logic [31:0]           w_merged;
  logic [31:0]           w_load_data;
  logic                  w_unused;

  assign w_ready  = (r_state == IDLE) && rst_n;
  assign w_accept = bus.req_valid && w_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_size      = 3'd4;
    w_size_mask = 4'b1111;
    w_byte_mask = 32'hFFFF_FFFF;
    case (bus.req_funct3[1:0])
      2'b00: begin
        w_size      = 3'd1;
        w_size_mask = 4'b0001;
        w_byte_mask = 32'h0000_00FF;
      end
      2'b01: begin
        w_size      = 3'd2;
        w_size_mask = 4'b0011;
        w_byte_mask = 32'h0000_FFFF;
      end
      default: ;
    endcase
    if (bus.req_we)
      w_illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
    else
      w_illegal = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110);
  end

  assign w_off       = bus.req_addr[1:0];
  assign w_split     = ({1'b0, w_off} + w_size) > 3'd4;
  assign w_word      = bus.req_addr[ADDR_WIDTH+1:2];
  assign w_lane_mask = {4'b0000, w_size_mask} << w_off;
  assign w_lane_data = {32'h0, bus.req_wdata & w_byte_mask} << {w_off, 3'b000};

  // Aligned loads take every byte from the single word just read.
  assign w_lo_word = r_split ? r_lo_word : bus.mem_rdata;
  assign w_hi_word = r_split ? bus.mem_rdata : 32'h0;
  assign w_merged  = 32'({w_hi_word, w_lo_word} >> {r_off, 3'b000});

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_merged[7]}}, w_merged[7:0]};
      3'b001:  w_load_data = {{16{w_merged[15]}}, w_merged[15:0]};
      3'b100:  w_load_data = {24'h0, w_merged[7:0]};
      3'b101:  w_load_data = {16'h0, w_merged[15:0]};
      default: w_load_data = w_merged;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_addr  <= '0;
      r_mem_we    <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_off       <= '0;
      r_funct3    <= '0;
      r_split     <= 1'b0;
      r_hi_we     <= '0;
      r_hi_wdata  <= '0;
      r_lo_word   <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mem_addr <= w_word;
            r_off      <= w_off;
            r_funct3   <= bus.req_funct3;
            r_split    <= w_split;
            r_hi_we    <= w_lane_mask[7:4];
            r_hi_wdata <= w_lane_data[63:32];
            if (w_illegal) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else if (bus.req_we) begin
              r_mem_we    <= w_lane_mask[3:0];
              r_mem_wdata <= w_lane_data[31:0];
              r_state     <= ST_A;
            end else begin
              r_state <= LD_A;
            end
          end
        end
        LD_A: begin
          if (r_split) begin
            r_mem_addr <= r_mem_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            r_state    <= LD_B;
          end else begin
            r_state <= LD_W;
          end
        end
        LD_B: begin
          r_lo_word <= bus.mem_rdata;
          r_state   <= LD_W;
        end
        LD_W: begin
          r_rsp_rdata <= w_load_data;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_state     <= IDLE;
        end
        ST_A: begin
          if (r_split) begin
            r_mem_addr  <= r_mem_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            r_mem_we    <= r_hi_we;
            r_mem_wdata <= r_hi_wdata;
            r_state     <= ST_B;
          end else begin
            r_mem_we    <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_state     <= IDLE;
          end
        end
        ST_B: begin
          r_mem_we    <= '0;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wdata = r_mem_wdata;

  // Byte-address bits above the BRAM word range alias and are ignored.
  assign w_unused = &{1'b0, bus.req_addr[31:ADDR_WIDTH+2]};

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a byte-enable BRAM model with registered
// read behind the unit, hand-computed expected results for each access.
module tb_load_store_unit;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(AW), .BUS_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(AW), .BUS_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [31:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus.mem_we[i]) mem[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    check("ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_wdata  = 32'hFFFF_FFFF;
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat, output logic we_seen);
    int lat;
    lat     = 0;
    we_seen = 1'b0;
    while (!bus.rsp_valid && lat < 8) begin
      we_seen |= |bus.mem_we;
      @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid) lat = 99;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] addr0, input logic [31:0] addr1,
                         input int lat, input logic [31:0] exp);
    logic we_seen;
    issue(1'b0, f3, addr, 32'h0);
    check({tag, " addr0"}, 32'(bus.mem_addr), addr0);
    check({tag, " we0"}, 32'(bus.mem_we), 32'h0);
    if (lat == 3) begin
      @(negedge clk);
      check({tag, " addr1"}, 32'(bus.mem_addr), addr1);
      wait_rsp(tag, 2, we_seen);
    end else begin
      wait_rsp(tag, lat, we_seen);
    end
    check({tag, " we"}, 32'(we_seen), 32'h0);
    check({tag, " rdata"}, bus.rsp_rdata, exp);
    check({tag, " err"}, 32'(bus.rsp_err), 32'h0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_we, input logic [31:0] exp_wdata);
    logic we_seen;
    issue(1'b1, f3, addr, wdata);
    check({tag, " addr"}, 32'(bus.mem_addr), exp_addr);
    check({tag, " we"}, 32'(bus.mem_we), 32'(exp_we));
    check({tag, " wdata"}, bus.mem_wdata, exp_wdata);
    wait_rsp(tag, 1, we_seen);
    check({tag, " we off"}, 32'(bus.mem_we), 32'h0);
    check({tag, " rdata"}, bus.rsp_rdata, 32'h0);
    check({tag, " err"}, 32'(bus.rsp_err), 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ready"}, 32'(bus.req_ready), 32'h0);
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, " rsp_err"}, 32'(bus.rsp_err), 32'h0);
    check({tag, " rsp_rdata"}, bus.rsp_rdata, 32'h0);
    check({tag, " mem_addr"}, 32'(bus.mem_addr), 32'h0);
    check({tag, " mem_we"}, 32'(bus.mem_we), 32'h0);
    check({tag, " mem_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic we_seen;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Preload memory through aligned word stores.
    do_store("sw w0",   3'b010, 32'h0000_0000, 32'h8765_4321, 32'h0,    4'b1111, 32'h8765_4321);
    do_store("sw w1",   3'b010, 32'h0000_0004, 32'h0000_00A5, 32'h1,    4'b1111, 32'h0000_00A5);
    do_store("sw w2",   3'b010, 32'h0000_0008, 32'h0000_0000, 32'h2,    4'b1111, 32'h0000_0000);
    do_store("sw wtop", 3'b010, 32'h0000_7FFC, 32'h2222_1111, 32'h1FFF, 4'b1111, 32'h2222_1111);

    do_load("lb 3", 3'b000, 32'h3, 32'h0, 32'h0, 2, 32'hFFFF_FF87);
    @(negedge clk);
    check("rsp pulse", 32'(bus.rsp_valid), 32'h0);
    do_load("lbu 3", 3'b100, 32'h3, 32'h0, 32'h0, 2, 32'h0000_0087);
    do_load("lhu 3", 3'b101, 32'h3, 32'h0, 32'h1, 3, 32'h0000_A587);
    do_load("lh 3",  3'b001, 32'h3, 32'h0, 32'h1, 3, 32'hFFFF_A587);
    do_load("lhu 1", 3'b101, 32'h1, 32'h0, 32'h0, 2, 32'h0000_6543);

    // Split word store across words 1 and 2.
    issue(1'b1, 3'b010, 32'h6, 32'hDEAD_BEEF);
    check("sw6 addr0", 32'(bus.mem_addr), 32'h1);
    check("sw6 we0", 32'(bus.mem_we), 32'hC);
    check("sw6 wdata0", bus.mem_wdata, 32'hBEEF_0000);
    @(negedge clk);
    check("sw6 addr1", 32'(bus.mem_addr), 32'h2);
    check("sw6 we1", 32'(bus.mem_we), 32'h3);
    check("sw6 wdata1", bus.mem_wdata, 32'h0000_DEAD);
    wait_rsp("sw6", 1, we_seen);
    check("sw6 we off", 32'(bus.mem_we), 32'h0);
    check("sw6 rdata", bus.rsp_rdata, 32'h0);
    do_load("lw 4", 3'b010, 32'h4, 32'h1, 32'h1, 2, 32'hBEEF_00A5);
    do_load("lw 8", 3'b010, 32'h8, 32'h2, 32'h2, 2, 32'h0000_DEAD);

    // Reset while the split load sits in LD_B.
    issue(1'b0, 3'b101, 32'h3, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst valid", 32'(bus.rsp_valid), 32'h0);
    do_store("sb rst", 3'b000, 32'h1, 32'h0000_005A, 32'h0, 4'b0010, 32'h0000_5A00);

    // Wrap from the last word back to word 0.
    do_store("sw w0b", 3'b010, 32'h0, 32'h4444_3333, 32'h0, 4'b1111, 32'h4444_3333);
    do_load("wrap", 3'b010, 32'h7FFE, 32'h1FFF, 32'h0, 3, 32'h3333_2222);

    // Illegal load, then a store accepted in the error response cycle.
    issue(1'b0, 3'b011, 32'h0, 32'h0);
    wait_rsp("err", 0, we_seen);
    check("err flag", 32'(bus.rsp_err), 32'h1);
    check("err rdata", bus.rsp_rdata, 32'h0);
    check("err we", 32'(bus.mem_we), 32'h0);
    do_store("sb b2b", 3'b000, 32'h9, 32'hFFFF_FF12, 32'h2, 4'b0010, 32'h0000_1200);
    do_load("lw b2b", 3'b010, 32'h8, 32'h2, 32'h2, 2, 32'h0000_12AD);

    // Illegal store: no write, error response.
    issue(1'b1, 3'b100, 32'h0, 32'h1234_5678);
    check("serr we", 32'(bus.mem_we), 32'h0);
    wait_rsp("serr", 0, we_seen);
    check("serr flag", 32'(bus.rsp_err), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
